// File: rtl/pushbutton_conditioner_pkg.sv
// Shared constants and helpers for the pushbutton conditioner.
// Imported by the interface, the per-bit debouncer and the top level.
package pushbutton_conditioner_pkg;

    localparam int unsigned DEFAULT_WIDTH           = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned COUNT_WIDTH             = 8;

    typedef logic [COUNT_WIDTH-1:0] press_count_t;

    // Stability counter width; it only has to reach DEBOUNCE_CYCLES-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Button-side bundle: raw switch levels in, conditioned levels, pulses and count out.
// The conditioner uses the slave modport; the board/bench drives through master.
interface pushbutton_conditioner_if
    import pushbutton_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] raw_buttons;
    logic [WIDTH-1:0] buttons;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    press_count_t     press_count;

    modport master (
        output raw_buttons,
        input  buttons,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  raw_buttons,
        output buttons,
        output press_pulse,
        output release_pulse,
        output press_count
    );

endinterface

// File: rtl/pushbutton_conditioner_debounce_bit.sv
// One button bit: synchroniser chain, stability counter and accepted-level flop,
// with registered rise/fall pulses and the rise pulse's next state for counting.
module pushbutton_conditioner_debounce_bit
    import pushbutton_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_next
);

    localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;
    logic                   w_mismatch;
    logic                   w_accept;

    // Plain shift chain: nothing may sit between synchroniser stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_sync ^ r_level;
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_mismatch || w_accept) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_level <= w_accept ? w_sync : r_level;
            r_rise  <= w_accept & w_sync;
            r_fall  <= w_accept & ~w_sync;
        end
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_rise_next = w_accept & w_sync;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Pushbutton conditioner top: WIDTH independent debouncers plus a wrapping
// press counter that advances in the same cycle the press pulses appear.
module pushbutton_conditioner
    import pushbutton_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic                   clock,
    input logic                   reset,
    pushbutton_conditioner_if.slave btn
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_rise_next;
    press_count_t     w_inc;
    press_count_t     r_press_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pushbutton_conditioner_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock       (clock),
            .reset       (reset),
            .i_raw       (btn.raw_buttons[i]),
            .o_level     (w_level[i]),
            .o_rise      (w_rise[i]),
            .o_fall      (w_fall[i]),
            .o_rise_next (w_rise_next[i])
        );
    end

    // Popcount of the press pulses being registered this edge.
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_inc = w_inc + COUNT_WIDTH'(w_rise_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_press_count <= '0;
        end else begin
            r_press_count <= r_press_count + w_inc;
        end
    end

    assign btn.buttons       = w_level;
    assign btn.press_pulse   = w_rise;
    assign btn.release_pulse = w_fall;
    assign btn.press_count   = r_press_count;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor
// pops and compares them whenever a DUT raises a press or release pulse.
module tb_pushbutton_conditioner;
    import pushbutton_conditioner_pkg::*;

    typedef struct {
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] btn;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic clock = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc   = 0;
    bit   done  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] mb_a, mb_b;
    logic [7:0] cnt_a, cnt_b;

    pushbutton_conditioner_if #(.WIDTH(4)) if_a ();
    pushbutton_conditioner_if #(.WIDTH(4)) if_b ();

    pushbutton_conditioner #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut_a (
        .clock (clock),
        .reset (rst_a),
        .btn   (if_a.slave)
    );

    pushbutton_conditioner #(
        .WIDTH           (4),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1)
    ) dut_b (
        .clock (clock),
        .reset (rst_b),
        .btn   (if_b.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input bit fast, input logic rstn, input logic [3:0] b,
                       input logic [3:0] pp, input logic [3:0] rp, input logic [7:0] cnt);
        exp_t  e;
        string t;
        int    qs;
        t  = fast ? "B" : "A";
        qs = fast ? q_b.size() : q_a.size();
        if (!rstn) begin
            chk({t, "_rst_buttons"}, 32'(b), 0);
            chk({t, "_rst_press"}, 32'(pp), 0);
            chk({t, "_rst_release"}, 32'(rp), 0);
            chk({t, "_rst_count"}, 32'(cnt), 0);
        end else if ((pp | rp) !== 4'b0000) begin
            if (qs == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_unexpected: got pp=%b rp=%b, expected no pulse (cycle %0d)",
                         t, pp, rp, cyc);
            end else begin
                e = fast ? q_b.pop_front() : q_a.pop_front();
                chk({t, "_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({t, "_press"}, 32'(pp), 32'(e.pp));
                chk({t, "_release"}, 32'(rp), 32'(e.rp));
                chk({t, "_buttons"}, 32'(b), 32'(e.btn));
                chk({t, "_count"}, 32'(cnt), 32'(e.cnt));
            end
        end
    endtask

    always @(negedge clock) begin
        mon(1'b0, rst_a, if_a.buttons, if_a.press_pulse, if_a.release_pulse, if_a.press_count);
        mon(1'b1, rst_b, if_b.buttons, if_b.press_pulse, if_b.release_pulse, if_b.press_count);
        if (done) begin
            chk("A_queue_drained", 32'(q_a.size()), 0);
            chk("B_queue_drained", 32'(q_b.size()), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive a new raw level and queue the event it should produce after the full latency.
    task automatic apply(input bit fast, input logic [3:0] nv);
        exp_t       e;
        logic [3:0] old;
        logic [3:0] diff;
        old   = fast ? mb_b : mb_a;
        diff  = nv ^ old;
        e.pp  = diff & nv;
        e.rp  = diff & old;
        e.btn = nv;
        e.cyc = cyc + (fast ? 4 : 18);
        if (fast) begin
            if_b.raw_buttons = nv;
            cnt_b = cnt_b + 8'($countones(e.pp));
            e.cnt = cnt_b;
            mb_b  = nv;
            if (diff != 4'b0000) q_b.push_back(e);
        end else begin
            if_a.raw_buttons = nv;
            cnt_a = cnt_a + 8'($countones(e.pp));
            e.cnt = cnt_a;
            mb_a  = nv;
            if (diff != 4'b0000) q_a.push_back(e);
        end
    endtask

    initial begin
        mb_a = '0; mb_b = '0; cnt_a = '0; cnt_b = '0;
        if_a.raw_buttons = 4'b1111;
        if_b.raw_buttons = 4'b0000;

        // Reset held with all buttons pressed, then released: all four accepted together.
        step(5);
        rst_a = 1'b1;
        apply(1'b0, 4'b1111);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);

        // Clean press and release on bit 0.
        apply(1'b0, 4'b0001);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);

        // Bounce on bit 2: 15 high / 1 low never reaches acceptance.
        for (int k = 0; k < 10; k++) begin
            if_a.raw_buttons = 4'b0100;
            step(15);
            if_a.raw_buttons = 4'b0000;
            step(1);
        end
        apply(1'b0, 4'b0100);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);

        // Reset part-way through bit 1's count, then re-acceptance after release.
        if_a.raw_buttons = 4'b0010;
        step(12);
        rst_a = 1'b0;
        mb_a  = '0;
        cnt_a = '0;
        step(3);
        rst_a = 1'b1;
        apply(1'b0, 4'b0010);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);

        // Walk press_count up to 254, then a four-bit press wraps it to 2.
        for (int k = 0; k < 63; k++) begin
            apply(1'b0, 4'b1111);
            step(20);
            apply(1'b0, 4'b0000);
            step(20);
        end
        apply(1'b0, 4'b0001);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);
        apply(1'b0, 4'b1111);
        step(20);
        apply(1'b0, 4'b0000);
        step(20);

        // Synchronise-only instance: 4-edge latency and 1-cycle glitch pass-through.
        rst_b = 1'b1;
        step(5);
        apply(1'b1, 4'b1000);
        step(6);
        apply(1'b1, 4'b1001);
        step(1);
        apply(1'b1, 4'b1000);
        step(6);
        apply(1'b1, 4'b0000);
        step(6);

        done = 1'b1;
        step(2);
        $display("FAIL watchdog: got no summary, expected monitor to finish");
        $fatal(1);
    end

endmodule
